// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Generates the fetch PC and issues at most one outstanding icache request.
// Responses go into a circular fetch queue whose head is presented to decode.
// Branch and trap redirects flush the queue. A response that is still in flight
// at redirect time is dropped. A misaligned PC or an access fault parks the
// fetcher in HALT until the next redirect.
// Optional build macro: FETCH_PERF_CNT_EN adds the PERF_STALL_CNT output, a
// saturating count of cycles in which decode was ready but the queue was empty.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            REDIRECT_V,
    input  logic [XLEN-1:0] REDIRECT_PC,
    input  logic            TRAP_V,
    input  logic [XLEN-1:0] MTVEC,
    output logic            IC_REQ_V,
    output logic [XLEN-1:0] IC_REQ_PC,
    input  logic            IC_REQ_RDY,
    input  logic            IC_RSP_V,
    input  logic [31:0]     IC_RSP_INSTR,
    input  logic            IC_RSP_ERR,
    output logic            DE_V,
    output logic [31:0]     DE_IR,
    output logic [XLEN-1:0] DE_PC,
    output logic [XLEN-1:0] DE_NPC,
    output logic            DE_IAM,
    output logic            DE_IAF,
    input  logic            DE_RDY
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     PERF_STALL_CNT
`endif
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  req_pc_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // queue storage, one field per array
    logic [31:0]      ir_mem  [FQ_DEPTH];
    logic [XLEN-1:0]  pc_mem  [FQ_DEPTH];
    logic             iam_mem [FQ_DEPTH];
    logic             iaf_mem [FQ_DEPTH];

    logic             redirect;
    logic [XLEN-1:0]  redirect_target;
    logic             outstanding;
    logic [OCC_W-1:0] occupancy;
    logic             has_space;
    logic             has_room;
    logic             pc_aligned;
    logic             req_v;
    logic             req_fire;
    logic             push_v;
    logic [31:0]      push_ir;
    logic [XLEN-1:0]  push_pc;
    logic             push_iam;
    logic             push_iaf;
    logic             pop;

    // Redirect decode: a trap takes priority over a branch redirect.
    always_comb begin
        redirect        = TRAP_V | REDIRECT_V;
        redirect_target = TRAP_V ? MTVEC : REDIRECT_PC;
    end

    // Occupancy bookkeeping. Only WAIT and DROP have a response in flight.
    always_comb begin
        outstanding = (state_q == ST_WAIT) || (state_q == ST_DROP);
        occupancy   = OCC_W'(count_q) + OCC_W'(outstanding);
        has_space   = count_q < CNT_W'(FQ_DEPTH);
        has_room    = occupancy < OCC_W'(FQ_DEPTH);
        pc_aligned  = (pc_q[1:0] == 2'b00);
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A redirect overrides every state.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            // If the response lands in the redirect cycle itself it is
            // discarded there, so nothing remains in flight to drop.
            state_d = (outstanding && !IC_RSP_V) ? ST_DROP : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end else if (push_v) begin
                        state_d = ST_HALT;
                    end
                end
                ST_WAIT: begin
                    if (IC_RSP_V) begin
                        state_d = IC_RSP_ERR ? ST_HALT : ST_RUN;
                    end
                end
                ST_DROP: begin
                    if (IC_RSP_V) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State outputs: request valid and the queue push payload.
    always_comb begin
        req_v    = 1'b0;
        push_v   = 1'b0;
        push_ir  = '0;
        push_pc  = pc_q;
        push_iam = 1'b0;
        push_iaf = 1'b0;
        if (!RESET && !redirect) begin
            case (state_q)
                ST_RUN: begin
                    if (pc_aligned) begin
                        req_v = has_room;
                    end else if (has_space) begin
                        // misaligned PC becomes an exception entry with an empty IR
                        push_v   = 1'b1;
                        push_iam = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (IC_RSP_V) begin
                        push_v   = 1'b1;
                        push_ir  = IC_RSP_INSTR;
                        push_pc  = req_pc_q;
                        push_iaf = IC_RSP_ERR;
                    end
                end
                default: begin
                    req_v = 1'b0;
                end
            endcase
        end
    end

    // Handshake and pop qualification
    always_comb begin
        req_fire = req_v & IC_REQ_RDY;
        pop      = (count_q != '0) & DE_RDY & ~redirect;
    end

    // PC register and the address of the request that is in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            if (redirect) begin
                pc_q <= redirect_target;
            end else if (req_fire) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (req_fire) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // Queue pointers and count. A redirect empties the queue.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_v) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_v, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage write. Entries are only read once the count covers them.
    always_ff @(posedge CLK) begin
        if (push_v) begin
            ir_mem[wr_ptr_q]  <= push_ir;
            pc_mem[wr_ptr_q]  <= push_pc;
            iam_mem[wr_ptr_q] <= push_iam;
            iaf_mem[wr_ptr_q] <= push_iaf;
        end
    end

    // Icache request port
    always_comb begin
        IC_REQ_V  = req_v;
        IC_REQ_PC = pc_q;
    end

    // Decode port driven directly from the queue head
    always_comb begin
        DE_V   = (count_q != '0);
        DE_IR  = ir_mem[rd_ptr_q];
        DE_PC  = pc_mem[rd_ptr_q];
        DE_NPC = pc_mem[rd_ptr_q] + XLEN'(4);
        DE_IAM = iam_mem[rd_ptr_q];
        DE_IAF = iaf_mem[rd_ptr_q];
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count the cycles in which decode waits on an empty queue (saturating)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
        end else if (DE_RDY && (count_q == '0) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        PERF_STALL_CNT = stall_cnt_q;
    end
`endif

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 The module SHALL expose parameter XLEN, default 64, giving the PC/address width.
REQ-002 The module SHALL expose parameter FQ_DEPTH, default 4, giving fetch-queue entries (power of 2, ≥2).
REQ-003 The module SHALL expose parameter RESET_PC, default 0, giving the PC after reset.
REQ-004 The module SHALL have these ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REDIRECT_V  in  1  branch/jump redirect.
- REDIRECT_PC  in  XLEN  redirect target.
- TRAP_V  in  1  trap redirect; beats REDIRECT_V.
- MTVEC  in  XLEN  trap target.
- IC_REQ_V  out  1  icache request valid.
- IC_REQ_PC  out  XLEN  request address.
- IC_REQ_RDY  in  1  icache accepts the request.
- IC_RSP_V  in  1  response valid.
- IC_RSP_INSTR  in  32  instruction.
- IC_RSP_ERR  in  1  access fault.
- DE_V  out  1  queue head valid.
- DE_IR  out  32  head instruction.
- DE_PC  out  XLEN  head PC.
- DE_NPC  out  XLEN  head PC+4.
- DE_IAM  out  1  head misaligned-PC exception.
- DE_IAF  out  1  head access-fault exception.
- DE_RDY  in  1  decode pops the head.

Function
REQ-005 The icache request SHALL complete when IC_REQ_V&IC_REQ_RDY; at most one request SHALL be outstanding.
REQ-006 The FSM SHALL have states RUN, WAIT, DROP and HALT.
REQ-007 In RUN, IC_REQ_V SHALL be 1 when (occupancy + outstanding) < FQ_DEPTH and PC[1:0]==0; on acceptance the FSM SHALL go to WAIT and PC SHALL advance by 4 (XLEN wrap).
REQ-008 In RUN with PC[1:0]!=0, no request SHALL issue; an entry with DE_IAM=1 and IR=0 SHALL be pushed when space exists; then the FSM SHALL go to HALT.
REQ-009 In WAIT, IC_RSP_V SHALL push {instr, request PC, IAF=IC_RSP_ERR} and the FSM SHALL return to RUN; if IC_RSP_ERR=1 it SHALL go to HALT instead.
REQ-010 HALT SHALL issue no requests until a redirect.
REQ-011 A redirect (TRAP_V or REDIRECT_V) SHALL load PC with MTVEC or REDIRECT_PC, flush all queue entries the same cycle, and set the FSM to DROP if a response is outstanding (else RUN).
REQ-012 A response arriving in the same cycle as a redirect SHALL be discarded.
REQ-013 In DROP, the next IC_RSP_V SHALL be discarded and the FSM SHALL go to RUN; a further redirect in DROP SHALL update PC and stay in DROP.
REQ-014 The queue SHALL be a circular buffer with log2(FQ_DEPTH)-bit pointers and a (log2(FQ_DEPTH)+1)-bit count; push and pop in the same cycle SHALL leave count unchanged.
REQ-015 DE_* SHALL come combinationally from the head entry; DE_V=(count!=0); a pop SHALL occur on DE_V&DE_RDY&!redirect.
REQ-016 Fetch-to-DE_V latency SHALL be 1 cycle after IC_RSP_V (registered push); with IC_REQ_RDY=1 and single-cycle responses, throughput SHALL be one instruction per 2 cycles.
REQ-017 DE_NPC SHALL equal DE_PC+4 modulo 2^XLEN.

Reset
REQ-018 While RESET=1, PC SHALL be RESET_PC, FSM=RUN, count=0, pointers=0, outstanding=0, DE_V=0, IC_REQ_V=0; this SHALL take effect immediately, including mid-request.
REQ-019 A response arriving after reset deasserts with no outstanding request SHALL be ignored.

Configuration
REQ-020 When macro FETCH_PERF_CNT_EN is defined, the module SHALL add output PERF_STALL_CNT (32 bits, reset 0, saturating), incrementing each cycle where DE_RDY=1 and DE_V=0; when it is undefined the port and its logic SHALL be absent.

Verification
REQ-021 Reset release, RESET_PC=0x1000, icache ready with 1-cycle latency -> requests at 0x1000, 0x1004, 0x1008; DE_PC matches in order, DE_NPC=DE_PC+4.
REQ-022 DE_RDY=0 with FQ_DEPTH=4 -> exactly 4 entries accepted, then IC_REQ_V=0; one pop -> exactly one new request.
REQ-023 REDIRECT_PC=0x2000 while a response is outstanding -> queue empties, stale response dropped, first DE_PC=0x2000.
REQ-024 TRAP_V and REDIRECT_V in the same cycle, MTVEC=0x80 -> PC=0x80.
REQ-025 REDIRECT_PC=0x2002 -> one entry with DE_IAM=1, no IC_REQ_V until the next redirect; IC_RSP_ERR=1 -> DE_IAF=1, then HALT.
REQ-026 RESET asserted mid-WAIT with 3 entries queued -> DE_V=0 immediately; restart from RESET_PC; late response ignored.
